// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared response codes and FSM state encodings for the AXI-Lite RAM slave
// Contents:
//   RESP_OKAY / RESP_SLVERR  AXI response codes
//   w_state_t / W_*          write-channel FSM states
//   r_state_t / R_*          read-channel FSM states
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [1:0] w_state_t;
    localparam w_state_t W_IDLE    = 2'd0;
    localparam w_state_t W_HAVE_AW = 2'd1;
    localparam w_state_t W_HAVE_W  = 2'd2;
    localparam w_state_t W_RESP    = 2'd3;

    typedef logic [0:0] r_state_t;
    localparam r_state_t R_IDLE = 1'b0;
    localparam r_state_t R_RESP = 1'b1;

endpackage

// File: rtl/ram_1r1w_be.sv
// rtl/ram_1r1w_be.sv - 32-bit word RAM, one synchronous read port, one byte-enabled write port
// Ports:
//   clk            clock, all activity on posedge
//   rd_en/rd_idx   read request; rd_data updates on the following edge and holds otherwise
//   rd_data        registered read data (read-before-write on a same-word collision)
//   wr_en/wr_idx   write request and word index
//   wr_strb        byte-lane enables, bit n writes wr_data[8n+7:8n]
//   wr_data        write data
module ram_1r1w_be #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_strb,
    input  logic [31:0]      wr_data
);

    logic [31:0] mem [DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// rtl/axi_lite_ram_slave.sv - AXI4-Lite slave backed by a byte-enabled single-clock RAM
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   s_axi_aw*/s_axi_w*/s_axi_b* write address, data and response channels
//   s_axi_ar*/s_axi_r*         read address and data channels
// Option macro: AXI_RAM_SLVERR_EN - out-of-region accesses answer SLVERR instead of wrapping.
module axi_lite_ram_slave
    import axi_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          ID_WIDTH    = 4,
    parameter int          MEM_BYTES   = 4096,
    parameter logic [31:0] REGION_MASK = 32'h0FFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int IDX_W = $clog2(MEM_BYTES) - 2;
    localparam int DEPTH = MEM_BYTES / 4;

    w_state_t              w_state;
    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic                  rd_err_q;
    logic [31:0]           ram_rdata;

    // Readies are decoded from state and forced low while reset is asserted.
    assign s_axi_awready = !rst && (w_state == W_IDLE || w_state == W_HAVE_W);
    assign s_axi_wready  = !rst && (w_state == W_IDLE || w_state == W_HAVE_AW);
    assign s_axi_arready = !rst && (r_state == R_IDLE);
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_rvalid  = (r_state == R_RESP);

    logic aw_hs, w_hs, ar_hs, wr_commit;
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // The write commits on whichever edge completes the AW/W pair; each half
    // comes from its capture register if it arrived earlier, else from the bus.
    assign wr_commit = (w_state == W_IDLE    && aw_hs && w_hs) ||
                       (w_state == W_HAVE_AW && w_hs) ||
                       (w_state == W_HAVE_W  && aw_hs);

    logic [ADDR_WIDTH-1:0] wc_addr;
    logic [ID_WIDTH-1:0]   wc_id;
    logic [31:0]           wc_data;
    logic [3:0]            wc_strb;
    assign wc_addr = (w_state == W_HAVE_AW) ? aw_addr_q : s_axi_awaddr;
    assign wc_id   = (w_state == W_HAVE_AW) ? aw_id_q   : s_axi_awid;
    assign wc_data = (w_state == W_HAVE_W)  ? w_data_q  : s_axi_wdata;
    assign wc_strb = (w_state == W_HAVE_W)  ? w_strb_q  : s_axi_wstrb;

    logic wr_err, rd_err;
`ifdef AXI_RAM_SLVERR_EN
    localparam logic [ADDR_WIDTH-1:0] MASK  = ADDR_WIDTH'(REGION_MASK);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_BYTES);
    assign wr_err = (wc_addr & MASK) >= LIMIT;
    assign rd_err = (s_axi_araddr & MASK) >= LIMIT;
`else
    // Without the error option, high address bits simply alias into the RAM.
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{REGION_MASK,
                                wc_addr[ADDR_WIDTH-1:IDX_W+2], wc_addr[1:0],
                                s_axi_araddr[ADDR_WIDTH-1:IDX_W+2], s_axi_araddr[1:0]};
`endif

    ram_1r1w_be #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ar_hs),
        .rd_idx  (s_axi_araddr[IDX_W+1:2]),
        .rd_data (ram_rdata),
        .wr_en   (wr_commit && !wr_err),
        .wr_idx  (wc_addr[IDX_W+1:2]),
        .wr_strb (wc_strb),
        .wr_data (wc_data)
    );

    // Capture registers need no reset: the FSM reset discards whatever they hold.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_addr_q <= s_axi_awaddr;
            aw_id_q   <= s_axi_awid;
        end
        if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state     <= W_IDLE;
            s_axi_bid   <= '0;
            s_axi_bresp <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs && w_hs) w_state <= W_RESP;
                    else if (aw_hs)    w_state <= W_HAVE_AW;
                    else if (w_hs)     w_state <= W_HAVE_W;
                end
                W_HAVE_AW: if (w_hs)         w_state <= W_RESP;
                W_HAVE_W:  if (aw_hs)        w_state <= W_RESP;
                default:   if (s_axi_bready) w_state <= W_IDLE;
            endcase
            if (wr_commit) begin
                s_axi_bid   <= wc_id;
                s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            s_axi_rid   <= '0;
            s_axi_rresp <= RESP_OKAY;
            rd_err_q    <= 1'b0;
        end else begin
            if (r_state == R_IDLE) begin
                if (ar_hs) begin
                    r_state     <= R_RESP;
                    s_axi_rid   <= s_axi_arid;
                    s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    rd_err_q    <= rd_err;
                end
            end else if (s_axi_rready) begin
                r_state <= R_IDLE;
            end
        end
    end

    // RAM output only moves on an AR handshake, so rdata stays stable while rvalid waits.
    assign s_axi_rdata = (s_axi_rvalid && !rd_err_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb/tb_axi_lite_ram_slave.sv - scoreboard-checked directed bench for axi_lite_ram_slave
module tb_axi_lite_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    axi_lite_ram_slave dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
    } r_exp_t;

    b_exp_t      b_q[$];
    r_exp_t      r_q[$];
    logic [31:0] model [1024];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic addr_err(input logic [31:0] addr);
`ifdef AXI_RAM_SLVERR_EN
        return (addr & 32'h0FFF_FFFF) >= 32'd4096;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_write(input logic [31:0] addr, input logic [3:0] id,
                              input logic [31:0] data, input logic [3:0] strb);
        b_exp_t e;
        logic [9:0] idx;
        idx = addr[11:2];
        e.id = id;
        if (addr_err(addr)) begin
            e.resp = 2'b10;
        end else begin
            e.resp = 2'b00;
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        b_q.push_back(e);
    endtask

    task automatic push_read(input logic [31:0] addr, input logic [3:0] id);
        r_exp_t e;
        logic [9:0] idx;
        idx = addr[11:2];
        e.id = id;
        if (addr_err(addr)) begin
            e.resp = 2'b10;
            e.data = 32'h0;
        end else begin
            e.resp = 2'b00;
            e.data = model[idx];
        end
        r_q.push_back(e);
    endtask

    task automatic send_aw_w(input logic [31:0] addr, input logic [3:0] id,
                             input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        s_axi_awaddr = addr; s_axi_awid = id; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        while (!(s_axi_awready && s_axi_wready) && n < 20) begin tick(); n++; end
        check("aw_w_accept_timeout", 32'(n < 20), 32'd1);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        push_write(addr, id, data, strb);
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [3:0] id);
        int n = 0;
        s_axi_awaddr = addr; s_axi_awid = id; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 20) begin tick(); n++; end
        check("aw_accept_timeout", 32'(n < 20), 32'd1);
        tick();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 20) begin tick(); n++; end
        check("w_accept_timeout", 32'(n < 20), 32'd1);
        tick();
        s_axi_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] id);
        int n = 0;
        s_axi_araddr = addr; s_axi_arid = id; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 20) begin tick(); n++; end
        check("ar_accept_timeout", 32'(n < 20), 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        push_read(addr, id);
    endtask

    task automatic recv_b(input string tag);
        int n = 0;
        b_exp_t e;
        while (!s_axi_bvalid && n < 20) begin tick(); n++; end
        check({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
        if (b_q.size() == 0) begin
            check({tag, "_bq_nonempty"}, 32'(b_q.size()), 32'd1);
        end else begin
            e = b_q.pop_front();
            check({tag, "_bid"}, 32'(s_axi_bid), 32'(e.id));
            check({tag, "_bresp"}, 32'(s_axi_bresp), 32'(e.resp));
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check({tag, "_bvalid_drop"}, 32'(s_axi_bvalid), 32'd0);
    endtask

    task automatic recv_r(input string tag);
        int n = 0;
        r_exp_t e;
        while (!s_axi_rvalid && n < 20) begin tick(); n++; end
        check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
        if (r_q.size() == 0) begin
            check({tag, "_rq_nonempty"}, 32'(r_q.size()), 32'd1);
        end else begin
            e = r_q.pop_front();
            check({tag, "_rid"}, 32'(s_axi_rid), 32'(e.id));
            check({tag, "_rresp"}, 32'(s_axi_rresp), 32'(e.resp));
            check({tag, "_rdata"}, s_axi_rdata, e.data);
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check({tag, "_rvalid_drop"}, 32'(s_axi_rvalid), 32'd0);
    endtask

    task automatic write_read(input logic [31:0] addr, input logic [3:0] id,
                              input logic [31:0] data, input logic [3:0] strb, input string tag);
        send_aw_w(addr, id, data, strb);
        recv_b({tag, "_wr"});
        send_ar(addr, id + 4'd1);
        recv_r({tag, "_rd"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        int          accepts;
        b_exp_t      be;
        r_exp_t      re;

        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;

        // Reset state
        tick(); tick(); tick();
        check("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
        check("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_ids_resps", 32'({s_axi_bid, s_axi_bresp, s_axi_rid, s_axi_rresp}), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);

        // Same-cycle AW+W, then read back
        send_aw_w(32'h10, 4'd3, 32'hDEADBEEF, 4'hF);
        check("b_next_cycle", 32'(s_axi_bvalid), 32'd1);
        recv_b("basic_wr");
        send_ar(32'h10, 4'd5);
        check("r_next_cycle", 32'(s_axi_rvalid), 32'd1);
        recv_r("basic_rd");

        // W first, AW three cycles later, partial strobe
        send_w(32'h11112222, 4'b0011);
        check("w_first_wready_low", 32'(s_axi_wready), 32'd0);
        check("w_first_awready_high", 32'(s_axi_awready), 32'd1);
        tick(); tick();
        check("w_first_no_b", 32'(s_axi_bvalid), 32'd0);
        send_aw(32'h10, 4'd7);
        push_write(32'h10, 4'd7, 32'h11112222, 4'b0011);
        check("w_first_b_next", 32'(s_axi_bvalid), 32'd1);
        recv_b("w_first_wr");
        send_ar(32'h10, 4'd2);
        recv_r("partial_rd");

        // AW first, W later
        send_aw(32'h14, 4'd9);
        check("aw_first_awready_low", 32'(s_axi_awready), 32'd0);
        check("aw_first_wready_high", 32'(s_axi_wready), 32'd1);
        send_w(32'hA5A5A5A5, 4'b1000);
        push_write(32'h14, 4'd9, 32'hA5A5A5A5, 4'b1000);
        recv_b("aw_first_wr");
        send_ar(32'h14, 4'd1);
        recv_r("aw_first_rd");

        // Zero strobe leaves the word untouched
        write_read(32'h10, 4'd4, 32'hFFFFFFFF, 4'b0000, "strb0");

        // Backpressure on B and R
        send_aw_w(32'h30, 4'd9, 32'h0BADF00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check("bstall_bvalid", 32'(s_axi_bvalid), 32'd1);
            check("bstall_bid", 32'(s_axi_bid), 32'd9);
            check("bstall_readies", 32'({s_axi_awready, s_axi_wready}), 32'd0);
            tick();
        end
        recv_b("bstall");
        send_ar(32'h30, 4'd4);
        held = s_axi_rdata;
        for (int i = 0; i < 5; i++) begin
            check("rstall_rvalid", 32'(s_axi_rvalid), 32'd1);
            check("rstall_rdata", s_axi_rdata, held);
            tick();
        end
        recv_r("rstall");

        // Same-edge read and write to one word returns the old data
        send_aw_w(32'h20, 4'd1, 32'h0, 4'hF);
        recv_b("coll_init");
        s_axi_awaddr = 32'h20; s_axi_awid = 4'd8; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h20; s_axi_arid = 4'd6; s_axi_arvalid = 1'b1;
        check("coll_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        push_read(32'h20, 4'd6);
        push_write(32'h20, 4'd8, 32'h55, 4'hF);
        recv_b("coll_wr");
        recv_r("coll_rd_old");
        send_ar(32'h20, 4'd2);
        recv_r("coll_rd_new");

        // Randomised write/read pairs
        for (int i = 0; i < 6; i++) begin
            write_read(32'($urandom_range(0, 255)) << 2, 4'($urandom_range(0, 14)),
                       $urandom, 4'($urandom_range(0, 15)), "rand");
        end

        // Throughput: one write and one read every two cycles with readies held
        accepts = 0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        s_axi_awaddr = 32'h40; s_axi_awid = 4'd12; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (s_axi_bvalid) begin
                if (b_q.size() > 0) begin
                    be = b_q.pop_front();
                    check("tput_bid", 32'(s_axi_bid), 32'(be.id));
                end else begin
                    check("tput_bq_nonempty", 32'(b_q.size()), 32'd1);
                end
            end
            if (s_axi_awready && s_axi_wready) begin
                accepts++;
                push_write(32'h40, 4'd12, 32'h12345678, 4'hF);
            end
            tick();
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("tput_write_accepts", 32'(accepts), 32'd3);
        check("tput_bq_drained", 32'(b_q.size()), 32'd0);
        accepts = 0;
        s_axi_araddr = 32'h40; s_axi_arid = 4'd13; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (s_axi_rvalid) begin
                if (r_q.size() > 0) begin
                    re = r_q.pop_front();
                    check("tput_rdata", s_axi_rdata, re.data);
                end else begin
                    check("tput_rq_nonempty", 32'(r_q.size()), 32'd1);
                end
            end
            if (s_axi_arready) begin
                accepts++;
                push_read(32'h40, 4'd13);
            end
            tick();
        end
        s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        check("tput_read_accepts", 32'(accepts), 32'd3);
        check("tput_rq_drained", 32'(r_q.size()), 32'd0);

        // Out-of-region address: SLVERR when enabled, alias of word 0 otherwise
        write_read(32'h0, 4'd3, 32'h600DCAFE, 4'hF, "word0_init");
        write_read(32'h1000, 4'd5, 32'hCAFEF00D, 4'hF, "oor");
        send_ar(32'h0, 4'd7);
        recv_r("oor_word0");

        // Reset while a write response is pending
        send_aw_w(32'h50, 4'd11, 32'h87654321, 4'hF);
        check("rst_mid_bvalid", 32'(s_axi_bvalid), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_bvalid_clr", 32'(s_axi_bvalid), 32'd0);
        check("rst_mid_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
        b_q.delete();
        tick();
        rst = 1'b0;
        tick();
        check("rst_mid_release", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
        send_ar(32'h50, 4'd2);
        recv_r("ram_kept");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
